// File: rtl/pll_clken_gen_if.sv
// Configuration request channel for pll_clken_gen: one channel's ratio/phase per transfer.
interface pll_clken_gen_if #(
  parameter int NUM_CH = 6,
  parameter int W      = 8
);
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic           cfg_valid;
  logic           cfg_ready;
  logic [CHW-1:0] cfg_ch;
  logic [W-1:0]   cfg_mul;
  logic [W-1:0]   cfg_div;
  logic [W-1:0]   cfg_phase;
  logic           cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_mul, cfg_div, cfg_phase,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_mul, cfg_div, cfg_phase,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/pll_clken_gen.sv
// Fractional clock-enable generator: NUM_CH MUL/DIV accumulators with phase offset,
// lock supervision FSM and optional accumulator upset scrubbing.

// One output channel: phase accumulator producing clken pulses at MUL/DIV rate.
module pll_clken_ch #(
  parameter int W          = 8,
  parameter int IRRAD_MODE = 1
) (
  input  logic         inclk0,
  input  logic         areset_n,
  input  logic         pllena,
  input  logic         load,
  input  logic [W-1:0] ld_mul,
  input  logic [W-1:0] ld_div,
  input  logic [W-1:0] ld_phase,
  output logic         clken,
  output logic         c,
  output logic         seu_hit
);
  logic [W-1:0] mul, div, phase, acc;
  logic [W:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, mul};
  // acc >= div can never arise from legal operation, so it marks an upset
  assign seu_hit = (IRRAD_MODE != 0) && pllena && (mul != '0) && (acc >= div);

  // Config load wins over everything, then enable gating, then accumulation
  always_ff @(posedge inclk0 or negedge areset_n) begin
    if (!areset_n) begin
      mul   <= '0;
      div   <= W'(1);
      phase <= '0;
      acc   <= '0;
      clken <= 1'b0;
      c     <= 1'b0;
    end else if (load) begin
      mul   <= ld_mul;
      div   <= ld_div;
      phase <= ld_phase;
      acc   <= ld_phase;
      clken <= 1'b0;
      c     <= 1'b0;
    end else if (!pllena) begin
      acc   <= phase;
      clken <= 1'b0;
      c     <= 1'b0;
    end else if (mul == '0) begin
      acc   <= '0;
      clken <= 1'b0;
      c     <= 1'b0;
    end else if (seu_hit) begin
      acc   <= '0;
      clken <= 1'b0;
    end else if (sum >= {1'b0, div}) begin
      acc   <= W'(sum - {1'b0, div});
      clken <= 1'b1;
      c     <= ~c;
    end else begin
      acc   <= sum[W-1:0];
      clken <= 1'b0;
    end
  end
endmodule

module pll_clken_gen #(
  parameter int NUM_CH      = 6,
  parameter int W           = 8,
  parameter int LOCK_CYCLES = 16,
  parameter int IRRAD_MODE  = 1
) (
  input  logic              inclk0,
  input  logic              areset_n,
  input  logic              pllena,
  pll_clken_gen_if.slave    cfg,
  output logic [NUM_CH-1:0] clken,
  output logic [NUM_CH-1:0] c,
  output logic              locked,
  output logic              seu_err
);
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CW  = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CHW:0] NCH = (CHW+1)'(NUM_CH);

  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_SETTLE   = 2'd1;
  localparam logic [1:0] ST_LOCKED   = 2'd2;
  localparam logic [1:0] ST_APPLY    = 2'd3;

  logic [1:0]        st, st_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              fire, legal, accept, cfg_err_q;
  logic [NUM_CH-1:0] load, seu_hit;

  assign cfg.cfg_ready = (st != ST_APPLY);
  assign cfg.cfg_err   = cfg_err_q;
  assign locked        = (st == ST_LOCKED);

  assign fire   = cfg.cfg_valid & cfg.cfg_ready;
  assign legal  = ({1'b0, cfg.cfg_ch} < NCH) && (cfg.cfg_div != '0) &&
                  (cfg.cfg_mul <= cfg.cfg_div) && (cfg.cfg_phase < cfg.cfg_div);
  assign accept = fire & legal;

  // Lock FSM next state; pllena low overrides everything, accepts still load channels
  always_comb begin
    st_nxt  = st;
    cnt_nxt = '0;
    if (!pllena) begin
      st_nxt = ST_UNLOCKED;
    end else begin
      case (st)
        ST_UNLOCKED: st_nxt = accept ? ST_APPLY : ST_SETTLE;
        ST_SETTLE: begin
          if (accept)                            st_nxt = ST_APPLY;
          else if (cnt == CW'(LOCK_CYCLES - 1))  st_nxt = ST_LOCKED;
          else                                   cnt_nxt = cnt + 1'b1;
        end
        ST_LOCKED:   if (accept) st_nxt = ST_APPLY;
        default:     st_nxt = ST_SETTLE;
      endcase
    end
  end

  // FSM state and settle counter
  always_ff @(posedge inclk0 or negedge areset_n) begin
    if (!areset_n) begin
      st  <= ST_UNLOCKED;
      cnt <= '0;
    end else begin
      st  <= st_nxt;
      cnt <= cnt_nxt;
    end
  end

  // Reject pulse for bad requests; sticky upset flag
  always_ff @(posedge inclk0 or negedge areset_n) begin
    if (!areset_n) begin
      cfg_err_q <= 1'b0;
      seu_err   <= 1'b0;
    end else begin
      cfg_err_q <= fire & ~legal;
      seu_err   <= seu_err | (|seu_hit);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign load[i] = accept & (cfg.cfg_ch == CHW'(i));

    pll_clken_ch #(.W(W), .IRRAD_MODE(IRRAD_MODE)) u_ch (
      .inclk0   (inclk0),
      .areset_n (areset_n),
      .pllena   (pllena),
      .load     (load[i]),
      .ld_mul   (cfg.cfg_mul),
      .ld_div   (cfg.cfg_div),
      .ld_phase (cfg.cfg_phase),
      .clken    (clken[i]),
      .c        (c[i]),
      .seu_hit  (seu_hit[i])
    );
  end
endmodule

// File: tb/tb_pll_clken_gen.sv
// Directed bench for pll_clken_gen: config table, cadence, lock, pllena drop, scrub, reset.
module tb_pll_clken_gen;
  logic       inclk0 = 1'b0;
  logic       areset_n;
  logic       pllena;
  logic [5:0] clken, c;
  logic       locked, seu_err;
  int         checks = 0;
  int         errors = 0;

  pll_clken_gen_if #(.NUM_CH(6), .W(8)) cfg_if ();

  pll_clken_gen #(.NUM_CH(6), .W(8), .LOCK_CYCLES(16), .IRRAD_MODE(1)) dut (
    .inclk0   (inclk0),
    .areset_n (areset_n),
    .pllena   (pllena),
    .cfg      (cfg_if),
    .clken    (clken),
    .c        (c),
    .locked   (locked),
    .seu_err  (seu_err)
  );

  always #5 inclk0 = ~inclk0;

  typedef struct {
    logic [2:0] ch;
    logic [7:0] mul;
    logic [7:0] div;
    logic [7:0] ph;
    logic       err;
  } cfg_vec_t;

  cfg_vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge inclk0);
    @(negedge inclk0);
  endtask

  task automatic drive(input logic [2:0] ch, input logic [7:0] mul,
                       input logic [7:0] div, input logic [7:0] ph);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = ch;
    cfg_if.cfg_mul   = mul;
    cfg_if.cfg_div   = div;
    cfg_if.cfg_phase = ph;
  endtask

  // Hand-derived cadence of the configured channels, k edges after (re)start.
  // ch0/ch2: 1/4 from phase 0; ch3: 4/4 from phase 3; ch1: 3/8 from phase 0 or 5.
  function automatic logic [11:0] model(input int k, input bit ph5);
    logic [5:0] ke, cv;
    int r, p;
    ke = '0;
    cv = '0;
    ke[0] = (k % 4 == 3);
    cv[0] = (((k + 1) / 4) % 2) == 1;
    ke[2] = ke[0];
    cv[2] = cv[0];
    r = k % 8;
    if (ph5) begin
      ke[1] = (r == 0) || (r == 3) || (r == 6);
      p = (k / 8) * 3 + 1 + int'(r >= 3) + int'(r >= 6);
    end else begin
      ke[1] = (r == 2) || (r == 5) || (r == 7);
      p = (k / 8) * 3 + int'(r >= 2) + int'(r >= 5) + int'(r >= 7);
    end
    cv[1] = (p % 2) == 1;
    ke[3] = 1'b1;
    cv[3] = ((k + 1) % 2) == 1;
    return {cv, ke};
  endfunction

  initial begin
    logic [11:0] o, on;

    tbl[0] = '{ch: 3'd0, mul: 8'd1, div: 8'd4, ph: 8'd0, err: 1'b0};
    tbl[1] = '{ch: 3'd0, mul: 8'd5, div: 8'd4, ph: 8'd0, err: 1'b1};
    tbl[2] = '{ch: 3'd0, mul: 8'd1, div: 8'd0, ph: 8'd0, err: 1'b1};
    tbl[3] = '{ch: 3'd6, mul: 8'd1, div: 8'd4, ph: 8'd0, err: 1'b1};
    tbl[4] = '{ch: 3'd0, mul: 8'd2, div: 8'd4, ph: 8'd4, err: 1'b1};
    tbl[5] = '{ch: 3'd1, mul: 8'd3, div: 8'd8, ph: 8'd0, err: 1'b0};
    tbl[6] = '{ch: 3'd2, mul: 8'd1, div: 8'd4, ph: 8'd0, err: 1'b0};
    tbl[7] = '{ch: 3'd3, mul: 8'd4, div: 8'd4, ph: 8'd3, err: 1'b0};

    areset_n = 1'b0;
    pllena   = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch    = '0;
    cfg_if.cfg_mul   = '0;
    cfg_if.cfg_div   = '0;
    cfg_if.cfg_phase = '0;
    repeat (2) @(negedge inclk0);

    chk("rst_clken",  32'(clken), 32'd0);
    chk("rst_c",      32'(c), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_cfgerr", 32'(cfg_if.cfg_err), 32'd0);
    chk("rst_seu",    32'(seu_err), 32'd0);
    chk("rst_ready",  32'(cfg_if.cfg_ready), 32'd1);
    areset_n = 1'b1;
    tick();

    // Config table with pllena low: state stays UNLOCKED, so ready stays high
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].ch, tbl[i].mul, tbl[i].div, tbl[i].ph);
      tick();
      chk("tbl_err",   32'(cfg_if.cfg_err), 32'(tbl[i].err));
      chk("tbl_ready", 32'(cfg_if.cfg_ready), 32'd1);
      cfg_if.cfg_valid = 1'b0;
      tick();
      chk("tbl_err_clr", 32'(cfg_if.cfg_err), 32'd0);
    end

    // Cadence and lock from SETTLE entry (edge 0)
    pllena = 1'b1;
    for (int n = 0; n < 24; n++) begin
      tick();
      o = model(n, 1'b0);
      chk("run_clken",  32'(clken), 32'(o[5:0]));
      chk("run_c",      32'(c), 32'(o[11:6]));
      chk("run_locked", 32'(locked), 32'(n >= 16));
    end

    // Illegal request while locked: pulse only, nothing else moves
    drive(3'd0, 8'd5, 8'd4, 8'd0);
    tick();
    o = model(24, 1'b0);
    chk("ill_err",    32'(cfg_if.cfg_err), 32'd1);
    chk("ill_locked", 32'(locked), 32'd1);
    chk("ill_ready",  32'(cfg_if.cfg_ready), 32'd1);
    chk("ill_clken",  32'(clken), 32'(o[5:0]));
    chk("ill_c",      32'(c), 32'(o[11:6]));
    cfg_if.cfg_valid = 1'b0;
    tick();
    o = model(25, 1'b0);
    chk("ill_err_clr", 32'(cfg_if.cfg_err), 32'd0);
    chk("ill_clken2",  32'(clken), 32'(o[5:0]));

    // Legal reconfig of ch1 with phase 5 while locked
    drive(3'd1, 8'd3, 8'd8, 8'd5);
    for (int n = 26; n < 46; n++) begin
      tick();
      cfg_if.cfg_valid = 1'b0;
      o = model(n, 1'b0);
      if (n == 26) begin
        o[1] = 1'b0;
        o[7] = 1'b0;
      end else begin
        on = model(n - 27, 1'b1);
        o[1] = on[1];
        o[7] = on[7];
      end
      chk("rcf_clken",  32'(clken), 32'(o[5:0]));
      chk("rcf_c",      32'(c), 32'(o[11:6]));
      chk("rcf_locked", 32'(locked), 32'(n >= 43));
      chk("rcf_ready",  32'(cfg_if.cfg_ready), 32'(n != 26));
    end

    // pllena drop and restart from phase
    pllena = 1'b0;
    for (int n = 46; n < 48; n++) begin
      tick();
      chk("off_clken",  32'(clken), 32'd0);
      chk("off_c",      32'(c), 32'd0);
      chk("off_locked", 32'(locked), 32'd0);
    end
    pllena = 1'b1;
    for (int n = 48; n < 67; n++) begin
      tick();
      o = model(n - 48, 1'b1);
      chk("rst_run_clken",  32'(clken), 32'(o[5:0]));
      chk("rst_run_c",      32'(c), 32'(o[11:6]));
      chk("rst_run_locked", 32'(locked), 32'(n >= 64));
    end

    // Upset on ch2 at an edge where it would otherwise pulse
    force dut.g_ch[2].u_ch.acc = 8'd5;
    #1;
    release dut.g_ch[2].u_ch.acc;
    tick();
    chk("seu_flag",   32'(seu_err), 32'd1);
    chk("seu_locked", 32'(locked), 32'd1);
    chk("seu_acc",    32'(dut.g_ch[2].u_ch.acc), 32'd0);
    chk("seu_clken2", 32'(clken[2]), 32'd0);
    chk("seu_clken0", 32'(clken[0]), 32'd1);
    for (int j = 1; j <= 4; j++) begin
      tick();
      chk("seu_recad", 32'(clken[2]), 32'(j == 4));
      chk("seu_stick", 32'(seu_err), 32'd1);
    end

    // Asynchronous reset mid-cycle
    #2;
    areset_n = 1'b0;
    #1;
    chk("arst_clken",  32'(clken), 32'd0);
    chk("arst_c",      32'(c), 32'd0);
    chk("arst_locked", 32'(locked), 32'd0);
    chk("arst_seu",    32'(seu_err), 32'd0);
    chk("arst_cfgerr", 32'(cfg_if.cfg_err), 32'd0);
    chk("arst_ready",  32'(cfg_if.cfg_ready), 32'd1);
    @(negedge inclk0);
    areset_n = 1'b1;
    repeat (5) tick();
    chk("post_clken", 32'(clken), 32'd0);
    chk("post_c",     32'(c), 32'd0);
    chk("post_seu",   32'(seu_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
